// File: rtl/freq_analysis_if.sv
// Frame/result bundle between the FFT stage and the peak-bin finder.
interface freq_analysis_if;
    logic             fft_valid;
    logic [15:0][31:0] fft_d;     // bin k: [31:16] signed real, [15:0] signed imag
    logic             busy;
    logic             done;
    logic [3:0]       freq;
    logic [31:0]      mag_max;

    modport master (
        output fft_valid, fft_d,
        input  busy, done, freq, mag_max
    );

    modport slave (
        input  fft_valid, fft_d,
        output busy, done, freq, mag_max
    );
endinterface

// File: rtl/freq_analysis.sv
// Peak-bin finder: buffers a 16-bin FFT frame on a rising fft_valid and
// scans it one bin per cycle with a single squarer pair, reporting the
// index and squared magnitude of the strongest bin.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a rising edge of fft_valid
// CALC  | evaluating buffered bin r_idx (0..15), one per cycle
// DONE  | result just published; done high for this one cycle
module freq_analysis (
    input  logic            clk,
    input  logic            rst,
    freq_analysis_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_valid_d;
    logic [31:0]   r_buf [16];
    logic [3:0]    r_idx;
    logic [31:0]   r_max;
    logic [3:0]    r_max_idx;
    logic          r_done;
    logic [3:0]    r_freq;
    logic [31:0]   r_mag;

    logic          w_rise;
    logic          w_accept;
    logic [31:0]   w_cur;
    logic signed [31:0] w_re;
    logic signed [31:0] w_im;
    logic signed [31:0] w_re_sq;
    logic signed [31:0] w_im_sq;
    logic [31:0]   w_mag;
    logic          w_take;
    logic [31:0]   w_max_nxt;
    logic [3:0]    w_idx_nxt;

    // A held-high fft_valid must not retrigger; rises during CALC are dropped.
    assign w_rise   = bus.fft_valid & ~r_valid_d;
    assign w_accept = w_rise & (r_state != CALC);

    // Shared squarer pair; each square is at most 2^30, so the sum fits 32 bits unsigned.
    assign w_cur     = r_buf[r_idx];
    assign w_re      = {{16{w_cur[31]}}, w_cur[31:16]};
    assign w_im      = {{16{w_cur[15]}}, w_cur[15:0]};
    assign w_re_sq   = w_re * w_re;
    assign w_im_sq   = w_im * w_im;
    assign w_mag     = $unsigned(w_re_sq) + $unsigned(w_im_sq);

    // Bin 0 seeds the running max; later bins need strictly greater, so ties keep the lower index.
    assign w_take    = (r_idx == 4'd0) || (w_mag > r_max);
    assign w_max_nxt = w_take ? w_mag : r_max;
    assign w_idx_nxt = w_take ? r_idx : r_max_idx;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = CALC;
            CALC:    if (r_idx == 4'd15) w_state_nxt = DONE;
            DONE:    w_state_nxt = w_accept ? CALC : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Frame capture, bin scan and result publication.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid_d <= 1'b0;
            r_idx     <= '0;
            r_max     <= '0;
            r_max_idx <= '0;
            r_done    <= 1'b0;
            r_freq    <= '0;
            r_mag     <= '0;
            for (int k = 0; k < 16; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            r_valid_d <= bus.fft_valid;
            r_done    <= 1'b0;
            if (w_accept) begin
                for (int k = 0; k < 16; k++) begin
                    r_buf[k] <= bus.fft_d[k];
                end
                r_idx <= '0;
            end else if (r_state == CALC) begin
                r_max     <= w_max_nxt;
                r_max_idx <= w_idx_nxt;
                r_idx     <= r_idx + 4'd1;
                if (r_idx == 4'd15) begin
                    r_freq <= w_idx_nxt;
                    r_mag  <= w_max_nxt;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign bus.busy    = (r_state == CALC);
    assign bus.done    = r_done;
    assign bus.freq    = r_freq;
    assign bus.mag_max = r_mag;

endmodule

// File: doc/freq_analysis.md
FREQ_ANALYSIS -- requirements
Module: freq_analysis

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-004 Port: fft_valid  input  1  frame-ready level from the FFT stage; may stay high across many cycles.
REQ-005 Ports: fft_d0..fft_d15  input  32 each  FFT bin k; [31:16] = signed real, [15:0] = signed imag.
REQ-006 Port: busy  output  1  high while a frame is being evaluated.
REQ-007 Port: done  output  1  one-cycle pulse marking a new result.
REQ-008 Port: freq  output  4  index of the bin with largest magnitude; held until the next result.
REQ-009 Port: mag_max  output  32  unsigned squared magnitude of bin freq; held with freq.

Function
REQ-010 The block SHALL register fft_valid each cycle (fft_valid_d) and SHALL accept a frame only on a rising edge (fft_valid=1, fft_valid_d=0).
REQ-011 The state machine SHALL have the states IDLE, CALC and DONE.
REQ-012 On accept in IDLE or DONE, all 16 bins SHALL be copied into an internal buffer, the index SHALL be set to 0, and the state SHALL go to CALC.
REQ-013 In CALC, exactly one bin per cycle SHALL be evaluated, in index order 0..15, using a single shared squarer pair.
REQ-014 Magnitude SHALL be re*re + im*im, with re and im signed 16-bit, and the result SHALL be 32-bit unsigned with no truncation (maximum 2^31 at -32768,-32768).
REQ-015 Bin 0 SHALL unconditionally load the running max and index.
REQ-016 Bins 1..15 SHALL replace the running max only when strictly greater, so on a tie the lowest index wins.
REQ-017 On the edge that evaluates bin 15, freq and mag_max SHALL be updated, including bin 15 in the comparison.
REQ-018 On that same edge, done SHALL be set to 1 and the state SHALL go to DONE.
REQ-019 Latency: the accept edge is E0, bins are evaluated on E1..E16, and done is high during the cycle after E16 for exactly one cycle.
REQ-020 In DONE, done SHALL clear on the next edge and the state SHALL return to IDLE, unless an accept occurs on that edge (REQ-012).
REQ-021 busy SHALL be 1 exactly while the state is CALC.
REQ-022 A rising edge of fft_valid during CALC SHALL be ignored; the frame in progress completes using buffered data, and fft_valid_d still tracks the input.
REQ-023 Changes on fft_d* after the accept edge SHALL NOT affect the current result.
REQ-024 freq and mag_max SHALL change only on the edge that sets done.

Reset
REQ-025 With rst=0 at a clock edge: state=IDLE; done=0, busy=0, freq=0, mag_max=0; fft_valid_d=0; index, running max and buffer cleared.
REQ-026 A reset during CALC SHALL abort the frame with no done pulse.
REQ-027 After reset release, a fft_valid already high SHALL count as a rising edge, because fft_valid_d=0.
REQ-028 rst SHALL take priority over accept and over all state transitions.

Verification
REQ-029 Single tone: fft_d5=32'h0100_0000, others 0, fft_valid rises -> busy for 16 cycles, then done pulse with freq=5, mag_max=32'h0001_0000.
REQ-030 Tie: fft_d3=fft_d9=32'h0000_0010, others 0 -> freq=3, mag_max=32'h0000_0100.
REQ-031 Extremes: fft_d12=32'h8000_8000, all others 32'h7FFF_0000 -> freq=12, mag_max=32'h8000_0000.
REQ-032 Level handling: fft_valid held high for 40 cycles -> exactly one done; drop it, then raise it with fft_d2=32'h0000_0200 only -> second done with freq=2, mag_max=32'h0004_0000.
REQ-033 Reset abort: rst=0 on edge E8 of CALC -> no done, freq=0, mag_max=0, busy=0; an all-zero frame afterwards -> done with freq=0, mag_max=0.
REQ-034 Back-to-back: a new fft_valid rise in the DONE cycle -> accepted, and a second done exactly 17 cycles after the first.
